// File: rtl/rgb_bargraph_pkg.sv
// Shared types for the RGB bargraph frame writer.
// States, colour indices and the captured pixel layout.
package rgb_bargraph_pkg;

  localparam int MAX_PIXELS = 128;

  localparam logic [1:0] COLOR_R = 2'd0;
  localparam logic [1:0] COLOR_G = 2'd1;
  localparam logic [1:0] COLOR_B = 2'd2;

  typedef enum logic [2:0] {
    ACCEPT,
    WR_R,
    WR_G,
    WR_B,
    SWAP,
    WAIT_SWAP
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/rgb_gamma_lut.sv
// 256-entry gamma-2.2 ROM, byte in / byte out.
// Only built when RGB_FRAME_WRITER_GAMMA_EN is defined.
module rgb_gamma_lut (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gamma(input int i);
    real v;
    v = 255.0 * $pow(real'(i) / 255.0, 2.2) + 0.5;
    return 8'($rtoi(v));
  endfunction

  logic [7:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = gamma(i);
  end

  assign dout = rom[din];

endmodule

// File: rtl/rgb_bargraph_frame_writer.sv
// Pixel stream to bargraph matrix byte writes, with double-buffer swap.
// Define RGB_FRAME_WRITER_GAMMA_EN to route bytes through the gamma ROM.
module rgb_bargraph_frame_writer
  import rgb_bargraph_pkg::*;
#(
  parameter int NUM_PIXELS   = 128,
  parameter int SWAP_TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_last,
  output logic        mtrx_wr,
  output logic [8:0]  mtrx_wr_addr,
  output logic [7:0]  mtrx_wr_data,
  output logic        mtrx_buffer_select,
  input  logic        mtrx_buffer_current,
  output logic        frame_done,
  output logic        err_short,
  output logic        err_long,
  output logic        err_swap_to,
  input  logic        err_clear
);

  localparam logic [7:0]  NPIX     = 8'(NUM_PIXELS);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_PIXELS - 1);
  localparam logic [15:0] TO_LAST  = 16'(SWAP_TIMEOUT - 1);

  state_t      state;
  state_t      state_n;
  pixel_t      pix;
  logic        last;
  logic [7:0]  idx;
  logic [15:0] cnt;
  logic [1:0]  cur_sync;
  logic        matched;
  logic        timeout;
  logic        is_wr;
  logic        long_px;
  logic [1:0]  color;
  logic [7:0]  raw;
  logic [7:0]  byte_out;
  logic        set_short;
  logic        set_long;
  logic        set_to;

  assign matched = cur_sync[1] == mtrx_buffer_select;
  assign timeout = cnt >= TO_LAST;
  assign long_px = idx >= NPIX;

  always_comb begin
    state_n = state;
    unique case (state)
      ACCEPT:    if (s_valid && s_ready) state_n = WR_R;
      WR_R:      state_n = WR_G;
      WR_G:      state_n = WR_B;
      WR_B:      state_n = last ? SWAP : ACCEPT;
      SWAP:      state_n = WAIT_SWAP;
      WAIT_SWAP: if (matched || timeout) state_n = ACCEPT;
      default:   state_n = ACCEPT;
    endcase
  end

  always_comb begin
    color = COLOR_R;
    raw   = '0;
    is_wr = 1'b0;
    unique case (1'b1)
      state == WR_R: begin
        color = COLOR_R;
        raw   = pix.r;
        is_wr = 1'b1;
      end
      state == WR_G: begin
        color = COLOR_G;
        raw   = pix.g;
        is_wr = 1'b1;
      end
      state == WR_B: begin
        color = COLOR_B;
        raw   = pix.b;
        is_wr = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef RGB_FRAME_WRITER_GAMMA_EN
  rgb_gamma_lut u_gamma (
    .din  (raw),
    .dout (byte_out)
  );
`else
  assign byte_out = raw;
`endif

  // Pixels past the frame length still step the FSM but never hit the bus.
  assign mtrx_wr      = is_wr & ~long_px;
  assign mtrx_wr_addr = is_wr ? {idx[6:0], color} : '0;
  assign mtrx_wr_data = is_wr ? byte_out : '0;

  assign frame_done = (state == WAIT_SWAP) & (matched | timeout);

  assign set_short = (state == WR_B) & last & (idx < LAST_IDX);
  assign set_long  = is_wr & long_px;
  assign set_to    = (state == WAIT_SWAP) & ~matched & timeout;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur_sync <= '0;
    end else begin
      cur_sync <= {cur_sync[0], mtrx_buffer_current};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state              <= ACCEPT;
      s_ready            <= 1'b0;
      pix                <= '0;
      last               <= 1'b0;
      idx                <= '0;
      cnt                <= '0;
      mtrx_buffer_select <= 1'b0;
      err_short          <= 1'b0;
      err_long           <= 1'b0;
      err_swap_to        <= 1'b0;
    end else begin
      state   <= state_n;
      s_ready <= state_n == ACCEPT;
      if (state == ACCEPT && s_valid && s_ready) begin
        pix  <= pixel_t'(s_data);
        last <= s_last;
      end
      // Select flips on entry to SWAP so the sync chain starts a cycle early.
      if (state == WR_B) begin
        if (last) begin
          mtrx_buffer_select <= ~mtrx_buffer_select;
        end else if (idx < NPIX) begin
          idx <= idx + 8'd1;
        end
      end
      if (state == SWAP) begin
        idx <= '0;
        cnt <= '0;
      end else if (state == WAIT_SWAP) begin
        cnt <= cnt + 16'd1;
      end
      err_short   <= (err_short & ~err_clear) | set_short;
      err_long    <= (err_long & ~err_clear) | set_long;
      err_swap_to <= (err_swap_to & ~err_clear) | set_to;
    end
  end

endmodule
